// File: rtl/program_counter.sv
// program_counter: SAP-U program counter.
// Holds the address of the next instruction. Under control-unit command it
// increments, loads a jump target from the 8-bit bus, or enters a sticky
// HALTED state that only reset can leave. It drives its value onto the bus
// when the control unit raises i_co.
//
// Build option: define PROGRAM_COUNTER_WRAP_FLAG_EN to compile the wrap
// detector. Without it, o_wrap is tied low and no wrap logic exists.
//
// Bus handshake: there is no valid/ready pair here. i_co is a level request
// sampled combinationally. o_bus_oe mirrors i_co in every state, including
// during reset. While o_bus_oe is high, o_bus_out carries the zero-extended
// counter; otherwise it is 8'h00. i_co never changes internal state.
//
// o_dbg_state exposes the FSM state for checkers: 0 = RUN, 1 = HALTED.
module program_counter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ce,
    input  logic             i_jump,
    input  logic             i_halt,
    input  logic             i_co,
    input  logic [7:0]       i_bus_in,
    output logic [WIDTH-1:0] o_pc,
    output logic [7:0]       o_bus_out,
    output logic             o_bus_oe,
    output logic             o_halted,
    output logic             o_wrap,
    output logic             o_dbg_state
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [7:0]       pc_ext;
    logic             unused_bus;

    // Only the low WIDTH bits of the bus feed a jump; the rest are dropped.
    assign unused_bus = ^i_bus_in;

    // Control FSM: priority halt > jump > count, and HALTED is sticky.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= RUN;
            pc_q    <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (i_halt) begin
                        state_q <= HALTED;
                    end else if (i_jump) begin
                        pc_q <= i_bus_in[WIDTH-1:0];
                    end else if (i_ce) begin
                        pc_q <= pc_q + WIDTH'(1);
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
    logic wrap_q;

    // One-cycle pulse on the edge where an increment rolls all-ones to zero.
    // A jump is never a wrap, and a halt in the same cycle suppresses it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= (state_q == RUN) && !i_halt && !i_jump && i_ce
                      && (pc_q == {WIDTH{1'b1}});
        end
    end

    assign o_wrap = wrap_q;
`else
    assign o_wrap = 1'b0;
`endif

    // Zero-extend the counter to the bus width; works for WIDTH up to 8.
    always_comb begin
        pc_ext              = '0;
        pc_ext[WIDTH-1:0]   = pc_q;
    end

    assign o_pc        = pc_q;
    assign o_halted    = (state_q == HALTED);
    assign o_dbg_state = state_q;
    assign o_bus_oe    = i_co;
    assign o_bus_out   = i_co ? pc_ext : 8'h00;

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed vector table plus a random phase against a
// small behavioural model, with a queue of expected post-edge results.
module tb_program_counter;

    localparam int WIDTH = 4;
    localparam int EW    = WIDTH + 2;
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             ce;
    logic             jump;
    logic             halt;
    logic             co;
    logic [7:0]       bus_in;
    logic [WIDTH-1:0] pc;
    logic [7:0]       bus_out;
    logic             bus_oe;
    logic             halted;
    logic             wrap;
    logic             dbg_state;

    program_counter #(.WIDTH(WIDTH)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_ce        (ce),
        .i_jump      (jump),
        .i_halt      (halt),
        .i_co        (co),
        .i_bus_in    (bus_in),
        .o_pc        (pc),
        .o_bus_out   (bus_out),
        .o_bus_oe    (bus_oe),
        .o_halted    (halted),
        .o_wrap      (wrap),
        .o_dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: {pc, halted, wrap} expected after each edge.
    logic [EW-1:0]    exp_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    logic [WIDTH-1:0] cur_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check the combinational bus path before the
    // edge, then check the registered outputs after it.
    task automatic step(input logic r, input logic c, input logic j, input logic h,
                        input logic o, input logic [7:0] b,
                        input logic [WIDTH-1:0] e_pc, input logic e_h, input logic e_w);
        logic [EW-1:0] e;
        logic [7:0]    e_bus;
        reset  = r;
        ce     = c;
        jump   = j;
        halt   = h;
        co     = o;
        bus_in = b;
        #1;
        e_bus = 8'h00;
        if (o) e_bus[WIDTH-1:0] = cur_pc;
        check("bus_oe", 32'(bus_oe), 32'(o));
        check("bus_out", 32'(bus_out), 32'(e_bus));
        exp_q.push_back({e_pc, e_h, e_w & WRAP_EN});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("pc", 32'(pc), 32'(e[EW-1:2]));
            check("halted", 32'(halted), 32'(e[1]));
            check("wrap", 32'(wrap), 32'(e[0]));
            check("dbg_state", 32'(dbg_state), 32'(e[1]));
        end
        cur_pc = e_pc;
    endtask

    typedef struct {
        logic             r, c, j, h, o;
        logic [7:0]       b;
        logic [WIDTH-1:0] e_pc;
        logic             e_h;
        logic             e_w;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, input logic c, input logic j, input logic h,
                                input logic o, input logic [7:0] b,
                                input logic [WIDTH-1:0] e_pc, input logic e_h, input logic e_w);
        vec_t v;
        v.r = r; v.c = c; v.j = j; v.h = h; v.o = o; v.b = b;
        v.e_pc = e_pc; v.e_h = e_h; v.e_w = e_w;
        return v;
    endfunction

    // Random-phase reference model state.
    logic [WIDTH-1:0] m_pc;
    logic             m_h;
    logic             m_w;

    initial begin
        //              r  c  j  h  o  bus     pc     h  w
        vecs[0]  = mk(1, 0, 0, 0, 1, 8'h00, 4'h0, 0, 0); // bus follows co during reset
        vecs[1]  = mk(0, 1, 0, 0, 0, 8'h00, 4'h1, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 8'h00, 4'h2, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 8'h00, 4'h3, 0, 0);
        vecs[4]  = mk(0, 1, 1, 0, 0, 8'hFA, 4'hA, 0, 0); // jump beats ce
        vecs[5]  = mk(0, 1, 0, 0, 1, 8'h00, 4'hB, 0, 0); // bus shows 0A
        vecs[6]  = mk(0, 0, 1, 0, 0, 8'h0F, 4'hF, 0, 0);
        vecs[7]  = mk(0, 1, 0, 0, 0, 8'h00, 4'h0, 0, 1); // wrap pulse
        vecs[8]  = mk(0, 0, 0, 0, 0, 8'h00, 4'h0, 0, 0); // pulse is one cycle
        vecs[9]  = mk(0, 0, 1, 0, 0, 8'h35, 4'h5, 0, 0); // upper bits ignored
        vecs[10] = mk(0, 0, 0, 0, 1, 8'h00, 4'h5, 0, 0); // bus 05
        vecs[11] = mk(0, 0, 0, 0, 0, 8'h00, 4'h5, 0, 0); // bus 00, pc held
        vecs[12] = mk(0, 0, 1, 0, 0, 8'h0F, 4'hF, 0, 0);
        vecs[13] = mk(0, 0, 1, 0, 0, 8'h00, 4'h0, 0, 0); // jump F->0 is not a wrap
        vecs[14] = mk(0, 0, 1, 0, 0, 8'h07, 4'h7, 0, 0);
        vecs[15] = mk(0, 1, 1, 1, 0, 8'h03, 4'h7, 1, 0); // halt discards ce/jump
        vecs[16] = mk(0, 1, 1, 0, 1, 8'h0C, 4'h7, 1, 0);
        vecs[17] = mk(0, 1, 1, 0, 0, 8'h0C, 4'h7, 1, 0);
        vecs[18] = mk(0, 1, 1, 0, 1, 8'h0C, 4'h7, 1, 0);
        vecs[19] = mk(0, 1, 1, 0, 0, 8'h0C, 4'h7, 1, 0);
        vecs[20] = mk(0, 1, 1, 1, 1, 8'h0C, 4'h7, 1, 0);
        vecs[21] = mk(1, 0, 1, 0, 0, 8'h0B, 4'h0, 0, 0); // reset beats jump mid-halt
        vecs[22] = mk(0, 1, 0, 0, 0, 8'h00, 4'h1, 0, 0);
        vecs[23] = mk(0, 0, 1, 0, 0, 8'h0F, 4'hF, 0, 0);
        vecs[24] = mk(0, 1, 0, 1, 0, 8'h00, 4'hF, 1, 0); // halt at F: no wrap
        vecs[25] = mk(0, 1, 0, 0, 0, 8'h00, 4'hF, 1, 0);
        vecs[26] = mk(1, 1, 0, 0, 1, 8'h00, 4'h0, 0, 0);

        reset  = 1'b1;
        ce     = 1'b0;
        jump   = 1'b0;
        halt   = 1'b0;
        co     = 1'b0;
        bus_in = 8'h00;
        cur_pc = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].r, vecs[i].c, vecs[i].j, vecs[i].h, vecs[i].o, vecs[i].b,
                 vecs[i].e_pc, vecs[i].e_h, vecs[i].e_w);
        end

        // Random phase: behavioural model predicts each edge.
        m_pc = cur_pc;
        m_h  = 1'b0;
        for (int k = 0; k < 300; k++) begin
            logic r, c, j, h, o;
            logic [7:0] b;
            r = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 3) != 0);
            j = ($urandom_range(0, 7) == 0);
            h = ($urandom_range(0, 29) == 0);
            o = $urandom_range(0, 1);
            b = 8'($urandom_range(0, 255));
            m_w = 1'b0;
            if (r) begin
                m_pc = '0;
                m_h  = 1'b0;
            end else if (m_h) begin
                m_h = 1'b1;
            end else if (h) begin
                m_h = 1'b1;
            end else if (j) begin
                m_pc = b[WIDTH-1:0];
            end else if (c) begin
                m_w  = (m_pc == {WIDTH{1'b1}});
                m_pc = m_pc + 1'b1;
            end
            step(r, c, j, h, o, b, m_pc, m_h, m_w);
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
